// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared definitions for the multi-cycle RV32I control unit:
//               FSM state encoding, major opcodes, datapath select encodings
//               and the bundled control-word type.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  // FSM states of the multi-cycle sequencer
  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_iarith = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  // Write-back source
  localparam logic [1:0] c_wb_aluout = 2'b00;
  localparam logic [1:0] c_wb_mdr    = 2'b01;
  localparam logic [1:0] c_wb_pc     = 2'b10;

  // ALU A input
  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_a     = 2'b01;
  localparam logic [1:0] c_srca_oldpc = 2'b10;

  // ALU B input
  localparam logic [1:0] c_srcb_b    = 2'b00;
  localparam logic [1:0] c_srcb_four = 2'b01;
  localparam logic [1:0] c_srcb_imm  = 2'b10;

  // ALU operation class
  localparam logic [1:0] c_aluop_add    = 2'b00;
  localparam logic [1:0] c_aluop_branch = 2'b01;
  localparam logic [1:0] c_aluop_funct  = 2'b10;

  // ECALL argument (x17) value that requests machine halt
  localparam logic [31:0] c_halt_code = 32'd10;

  // Complete set of per-cycle datapath controls
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op_sel;
    logic       pc_source;
    logic       is_halted;
  } ctrl_t;

  // True when the instruction in the IR is the halting ECALL
  function automatic logic is_halt_ecall(input logic [6:0] opcode,
                                         input logic [31:0] x17_val);
    return (opcode == c_op_system) && (x17_val == c_halt_code);
  endfunction

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_output_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mc_output_decoder
// Description : Purely combinational decode of (state, opcode, mem_ready)
//               into the datapath control word. Any field not set for a
//               state stays 0.
// Ports       : state_i     - current FSM state
//               opcode_i    - IR[6:0]
//               mem_ready_i - memory handshake (used only in IF)
//               ctrl_o      - bundled control outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mc_output_decoder
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_IF: begin
        // PC+4 is computed every IF cycle; the PC and IR only commit once
        // the fetch is actually delivered.
        ctrl_o.iord      = 1'b0;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_a = c_srca_pc;
        ctrl_o.alu_src_b = c_srcb_four;
        if (mem_ready_i) begin
          ctrl_o.ir_write  = 1'b1;
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = 1'b0;
        end
      end

      ST_ID: begin
        // Speculative branch/JAL target old_pc+imm lands in ALUOut
        ctrl_o.alu_src_a = c_srca_oldpc;
        ctrl_o.alu_src_b = c_srcb_imm;
      end

      ST_EX: begin
        case (opcode_i)
          c_op_rtype: begin
            ctrl_o.alu_src_a  = c_srca_a;
            ctrl_o.alu_src_b  = c_srcb_b;
            ctrl_o.alu_op_sel = c_aluop_funct;
          end
          c_op_iarith: begin
            ctrl_o.alu_src_a  = c_srca_a;
            ctrl_o.alu_src_b  = c_srcb_imm;
            ctrl_o.alu_op_sel = c_aluop_funct;
          end
          c_op_load, c_op_store: begin
            ctrl_o.alu_src_a  = c_srca_a;
            ctrl_o.alu_src_b  = c_srcb_imm;
            ctrl_o.alu_op_sel = c_aluop_add;
          end
          c_op_branch: begin
            ctrl_o.alu_src_a     = c_srca_a;
            ctrl_o.alu_src_b     = c_srcb_b;
            ctrl_o.alu_op_sel    = c_aluop_branch;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = 1'b1;
          end
          c_op_jal: begin
            // Target already sits in ALUOut from ID; PC still holds PC+4
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wb_sel    = c_wb_pc;
          end
          c_op_jalr: begin
            // rs1+imm goes straight to the PC; link written in same cycle
            ctrl_o.alu_src_a = c_srca_a;
            ctrl_o.alu_src_b = c_srcb_imm;
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = 1'b0;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wb_sel    = c_wb_pc;
          end
          default: begin
            // Unknown opcode executes as a NOP
          end
        endcase
      end

      ST_MEM: begin
        ctrl_o.iord = 1'b1;
        if (opcode_i == c_op_load) begin
          ctrl_o.mem_read = 1'b1;
        end else if (opcode_i == c_op_store) begin
          ctrl_o.mem_write = 1'b1;
        end
      end

      ST_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.wb_sel    = (opcode_i == c_op_load) ? c_wb_mdr : c_wb_aluout;
      end

      ST_HALT: begin
        ctrl_o.is_halted = 1'b1;
      end

      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule : mc_output_decoder
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : FSM sequencer for the shared multi-cycle RV32I datapath.
//               Holds the state register and next-state logic; control
//               outputs come from mc_output_decoder and are forced to 0
//               while reset is asserted.
// Ports       : clk_i, reset_i (async, active-high)
//               opcode_i, bcond_i, x17_val_i, mem_ready_i  - status inputs
//               pc_write_o ... is_halted_o                 - control outputs
//               cycle_cnt_o, instret_cnt_o                 - perf counters
// Config      : MC_PERF_CNT_EN - adds the cycle / retired-instruction
//               counters and their output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [6:0]  opcode_i,
  input  logic        bcond_i,
  input  logic [31:0] x17_val_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic [1:0]  wb_sel_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_sel_o,
  output logic        pc_source_o,
  output logic        is_halted_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_cnt_o
`endif
);

  state_e state_q;
  state_e state_d;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_out;

  // Branch qualification happens in the datapath; bcond is not consumed here
  logic w_unused_bcond;
  assign w_unused_bcond = bcond_i;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF: begin
        if (mem_ready_i) begin
          state_d = ST_ID;
        end
      end

      ST_ID: begin
        if (opcode_i == c_op_system) begin
          state_d = is_halt_ecall(opcode_i, x17_val_i) ? ST_HALT : ST_IF;
        end else begin
          state_d = ST_EX;
        end
      end

      ST_EX: begin
        case (opcode_i)
          c_op_rtype, c_op_iarith: state_d = ST_WB;
          c_op_load, c_op_store:   state_d = ST_MEM;
          default:                 state_d = ST_IF;
        endcase
      end

      ST_MEM: begin
        if (mem_ready_i) begin
          state_d = (opcode_i == c_op_load) ? ST_WB : ST_IF;
        end
      end

      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  mc_output_decoder u_decoder (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (w_ctrl)
  );

  // State is already IF during reset, but IF would otherwise drive
  // mem_read; every strobe is held low until reset is released.
  assign w_ctrl_out = reset_i ? '0 : w_ctrl;

  assign pc_write_o      = w_ctrl_out.pc_write;
  assign pc_write_cond_o = w_ctrl_out.pc_write_cond;
  assign iord_o          = w_ctrl_out.iord;
  assign mem_read_o      = w_ctrl_out.mem_read;
  assign mem_write_o     = w_ctrl_out.mem_write;
  assign ir_write_o      = w_ctrl_out.ir_write;
  assign reg_write_o     = w_ctrl_out.reg_write;
  assign wb_sel_o        = w_ctrl_out.wb_sel;
  assign alu_src_a_o     = w_ctrl_out.alu_src_a;
  assign alu_src_b_o     = w_ctrl_out.alu_src_b;
  assign alu_op_sel_o    = w_ctrl_out.alu_op_sel;
  assign pc_source_o     = w_ctrl_out.pc_source;
  assign is_halted_o     = w_ctrl_out.is_halted;

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_cnt_q;
  logic        w_retire;

  // An instruction retires when control returns to IF from any later
  // phase, or when the halting ECALL drops the machine into HALT.
  assign w_retire = ((state_d == ST_IF) &&
                     ((state_q == ST_ID) || (state_q == ST_EX) ||
                      (state_q == ST_MEM) || (state_q == ST_WB))) ||
                    ((state_d == ST_HALT) && (state_q != ST_HALT));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != ST_HALT) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (w_retire) begin
        instret_cnt_q <= instret_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`else
  // No counters in this build: the state register is the only storage.
`endif

endmodule : multicycle_control_unit
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. Each
//               instruction is expanded into a list of expected machine
//               phases (with random memory wait cycles) and every cycle's
//               control outputs are compared against a table of the
//               phase behaviour. Counters are checked when MC_PERF_CNT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  // Phase kinds used by the reference model
  localparam int K_ZERO     = 0;
  localparam int K_FETCH    = 1;
  localparam int K_DECODE   = 2;
  localparam int K_EX_R     = 3;
  localparam int K_EX_I     = 4;
  localparam int K_EX_ADDR  = 5;
  localparam int K_EX_BR    = 6;
  localparam int K_EX_JAL   = 7;
  localparam int K_EX_JALR  = 8;
  localparam int K_EX_NOP   = 9;
  localparam int K_MEM_LD   = 10;
  localparam int K_MEM_ST   = 11;
  localparam int K_WB_LD    = 12;
  localparam int K_WB_ALU   = 13;
  localparam int K_HALT     = 14;

  typedef struct {
    int kind;
    bit rdy;
    bit last;
  } step_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [6:0]  opcode_i = '0;
  logic        bcond_i = 1'b0;
  logic [31:0] x17_val_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
  logic        ir_write_o, reg_write_o, pc_source_o, is_halted_o;
  logic [1:0]  wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_sel_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_o, instret_cnt_o;
`endif

  int          checks = 0;
  int          failures = 0;
  int unsigned m_cycles = 0;
  int unsigned m_instret = 0;
  step_t       g_q[$];

  always #5 clk_i = ~clk_i;

  multicycle_control_unit dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .opcode_i        (opcode_i),
    .bcond_i         (bcond_i),
    .x17_val_i       (x17_val_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .iord_o          (iord_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .reg_write_o     (reg_write_o),
    .wb_sel_o        (wb_sel_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_sel_o    (alu_op_sel_o),
    .pc_source_o     (pc_source_o),
    .is_halted_o     (is_halted_o)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt_o     (cycle_cnt_o),
    .instret_cnt_o   (instret_cnt_o)
`endif
  );

  wire [16:0] w_act = {pc_write_o, pc_write_cond_o, iord_o, mem_read_o,
                       mem_write_o, ir_write_o, reg_write_o, wb_sel_o,
                       alu_src_a_o, alu_src_b_o, alu_op_sel_o, pc_source_o,
                       is_halted_o};

  // Expected control word for one cycle of a phase, straight from the
  // per-phase control table of the controller's behaviour.
  function automatic logic [16:0] exp_vec(input int k, input bit r);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, rw = 0;
    logic ps = 0, h = 0;
    logic [1:0] wb = 0, sa = 0, sb = 0, ao = 0;
    case (k)
      K_FETCH:   begin mr = 1; sa = 2'b00; sb = 2'b01; if (r) begin irw = 1; pw = 1; end end
      K_DECODE:  begin sa = 2'b10; sb = 2'b10; end
      K_EX_R:    begin sa = 2'b01; sb = 2'b00; ao = 2'b10; end
      K_EX_I:    begin sa = 2'b01; sb = 2'b10; ao = 2'b10; end
      K_EX_ADDR: begin sa = 2'b01; sb = 2'b10; ao = 2'b00; end
      K_EX_BR:   begin sa = 2'b01; sb = 2'b00; ao = 2'b01; pwc = 1; ps = 1; end
      K_EX_JAL:  begin pw = 1; ps = 1; rw = 1; wb = 2'b10; end
      K_EX_JALR: begin sa = 2'b01; sb = 2'b10; pw = 1; rw = 1; wb = 2'b10; end
      K_MEM_LD:  begin io = 1; mr = 1; end
      K_MEM_ST:  begin io = 1; mw = 1; end
      K_WB_LD:   begin rw = 1; wb = 2'b01; end
      K_WB_ALU:  begin rw = 1; wb = 2'b00; end
      K_HALT:    begin h = 1; end
      default:   begin end
    endcase
    return {pw, pwc, io, mr, mw, irw, rw, wb, sa, sb, ao, ps, h};
  endfunction

  function automatic string kind_name(input int k);
    case (k)
      K_FETCH:   return "IF";
      K_DECODE:  return "ID";
      K_EX_R:    return "EX_R";
      K_EX_I:    return "EX_I";
      K_EX_ADDR: return "EX_ADDR";
      K_EX_BR:   return "EX_BRANCH";
      K_EX_JAL:  return "EX_JAL";
      K_EX_JALR: return "EX_JALR";
      K_EX_NOP:  return "EX_NOP";
      K_MEM_LD:  return "MEM_LOAD";
      K_MEM_ST:  return "MEM_STORE";
      K_WB_LD:   return "WB_LOAD";
      K_WB_ALU:  return "WB_ALU";
      K_HALT:    return "HALT";
      default:   return "ZERO";
    endcase
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its phase list in g_q.
  task automatic build_instr(input logic [6:0] op, input logic [31:0] x17,
                             input int fs, input int ms, input int halt_cycles);
    g_q.delete();
    for (int i = 0; i < fs; i++) g_q.push_back('{K_FETCH, 1'b0, 1'b0});
    g_q.push_back('{K_FETCH, 1'b1, 1'b0});
    g_q.push_back('{K_DECODE, rnd_bit(), 1'b0});
    case (op)
      7'b0110011: begin
        g_q.push_back('{K_EX_R, rnd_bit(), 1'b0});
        g_q.push_back('{K_WB_ALU, rnd_bit(), 1'b0});
      end
      7'b0010011: begin
        g_q.push_back('{K_EX_I, rnd_bit(), 1'b0});
        g_q.push_back('{K_WB_ALU, rnd_bit(), 1'b0});
      end
      7'b0000011: begin
        g_q.push_back('{K_EX_ADDR, rnd_bit(), 1'b0});
        for (int i = 0; i < ms; i++) g_q.push_back('{K_MEM_LD, 1'b0, 1'b0});
        g_q.push_back('{K_MEM_LD, 1'b1, 1'b0});
        g_q.push_back('{K_WB_LD, rnd_bit(), 1'b0});
      end
      7'b0100011: begin
        g_q.push_back('{K_EX_ADDR, rnd_bit(), 1'b0});
        for (int i = 0; i < ms; i++) g_q.push_back('{K_MEM_ST, 1'b0, 1'b0});
        g_q.push_back('{K_MEM_ST, 1'b1, 1'b0});
      end
      7'b1100011: g_q.push_back('{K_EX_BR, rnd_bit(), 1'b0});
      7'b1101111: g_q.push_back('{K_EX_JAL, rnd_bit(), 1'b0});
      7'b1100111: g_q.push_back('{K_EX_JALR, rnd_bit(), 1'b0});
      7'b1110011: begin end
      default:    g_q.push_back('{K_EX_NOP, rnd_bit(), 1'b0});
    endcase
    g_q[g_q.size()-1].last = 1'b1;
    if (op == 7'b1110011 && x17 == 32'd10)
      for (int i = 0; i < halt_cycles; i++) g_q.push_back('{K_HALT, rnd_bit(), 1'b0});
  endtask

  // Play g_q: inputs driven on the falling edge, outputs sampled 1 ns
  // later, then the following rising edge advances the DUT.
  task automatic play(input string tname, input logic [6:0] op, input logic [31:0] x17);
    logic [16:0] e;
    for (int i = 0; i < g_q.size(); i++) begin
      opcode_i    = op;
      x17_val_i   = x17;
      mem_ready_i = g_q[i].rdy;
      bcond_i     = rnd_bit();
      #1;
      e = exp_vec(g_q[i].kind, g_q[i].rdy);
      checks++;
      if (w_act !== e) begin
        failures++;
        $display("FAIL %s step%0d %s: ctrl got=%05h expected=%05h",
                 tname, i, kind_name(g_q[i].kind), w_act, e);
      end
      @(negedge clk_i);
      if (g_q[i].kind != K_HALT) m_cycles++;
      if (g_q[i].last) m_instret++;
`ifdef MC_PERF_CNT_EN
      if (g_q[i].last || i == g_q.size() - 1) begin
        checks++;
        if (cycle_cnt_o !== m_cycles || instret_cnt_o !== m_instret) begin
          failures++;
          $display("FAIL %s counters: cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
                   tname, cycle_cnt_o, instret_cnt_o, m_cycles, m_instret);
        end
      end
`endif
    end
  endtask

  task automatic run_instr(input string tname, input logic [6:0] op,
                           input logic [31:0] x17, input int fs, input int ms,
                           input int halt_cycles);
    build_instr(op, x17, fs, ms, halt_cycles);
    play(tname, op, x17);
  endtask

  // Assert reset for one full cycle with mem_ready high; outputs must be 0.
  task automatic do_reset(input string tname);
    reset_i     = 1'b1;
    mem_ready_i = 1'b1;
    opcode_i    = 7'b0000011;
    #1;
    checks++;
    if (w_act !== 17'h0) begin
      failures++;
      $display("FAIL %s reset_outputs: ctrl got=%05h expected=00000", tname, w_act);
    end
`ifdef MC_PERF_CNT_EN
    checks++;
    if (cycle_cnt_o !== 32'd0 || instret_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL %s reset_counters: cycle=%0d instret=%0d expected 0 0",
               tname, cycle_cnt_o, instret_cnt_o);
    end
`endif
    @(negedge clk_i);
    reset_i   = 1'b0;
    m_cycles  = 0;
    m_instret = 0;
  endtask

  task automatic test_reset();
    do_reset("reset");
    // First cycle after release must be a fetch (ADD with one fetch wait)
    run_instr("reset_first_fetch", 7'b0110011, 32'd0, 1, 0, 0);
  endtask

  task automatic test_add();
    do_reset("add");
    run_instr("add", 7'b0110011, 32'd0, 0, 0, 0);
  endtask

  task automatic test_load_stall();
    run_instr("load_stall", 7'b0000011, 32'd0, 0, 2, 0);
  endtask

  task automatic test_branch();
    run_instr("branch", 7'b1100011, 32'd0, 0, 0, 0);
  endtask

  task automatic test_jalr();
    run_instr("jalr", 7'b1100111, 32'd0, 0, 0, 0);
    run_instr("jal", 7'b1101111, 32'd0, 1, 0, 0);
  endtask

  task automatic test_ecall_continue();
    run_instr("ecall_x17_9", 7'b1110011, 32'd9, 0, 0, 0);
  endtask

  task automatic test_reset_mid_store();
    g_q.delete();
    g_q.push_back('{K_FETCH, 1'b1, 1'b0});
    g_q.push_back('{K_DECODE, 1'b1, 1'b0});
    g_q.push_back('{K_EX_ADDR, 1'b1, 1'b0});
    g_q.push_back('{K_MEM_ST, 1'b0, 1'b0});
    play("store_pre_reset", 7'b0100011, 32'd0);
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if (mem_write_o !== 1'b1) begin
      failures++;
      $display("FAIL store_mem_write: got=%b expected=1", mem_write_o);
    end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (w_act !== 17'h0) begin
      failures++;
      $display("FAIL store_async_reset: ctrl got=%05h expected=00000", w_act);
    end
    @(negedge clk_i);
    do_reset("store_reset_hold");
    run_instr("after_store_reset", 7'b0110011, 32'd0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [31:0] x17;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b1110011, 7'b0000000, 7'b1111111};
    for (int n = 0; n < 150; n++) begin
      op  = ops[$urandom_range(0, 9)];
      x17 = $urandom;
      if (x17 == 32'd10) x17 = 32'd11;
      run_instr("random", op, x17, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
  endtask

  task automatic test_halt();
    run_instr("halt", 7'b1110011, 32'd10, 1, 0, 100);
    do_reset("halt_exit");
    run_instr("after_halt", 7'b0010011, 32'd0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_add();
    test_load_stall();
    test_branch();
    test_jalr();
    test_ecall_continue();
    test_reset_mid_store();
    test_random();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_multicycle_control_unit
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Finite-state controller that sequences the shared multi-cycle RV32I datapath: one ALU, one unified memory port, and the IR/MDR/A/B/ALUOut/old_pc registers.
- Each cycle it drives mux selects and write strobes from its current state and the opcode held in the IR.
- It stalls on a memory-ready handshake and stops the machine on the halting ECALL.

## Interface
Parameters:
- none; state codes, opcodes and select encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0].
- bcond  in  1  ALU branch-condition result.
- x17_val  in  32  value of register x17.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write qualified by bcond; qualification is done in the datapath.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load IR and old_pc (old_pc<=PC).
- reg_write  out  1  register-file write.
- wb_sel  out  2  write-back source: 00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  2  ALU A input: 00 PC, 01 A, 10 old_pc.
- alu_src_b  out  2  ALU B input: 00 B, 01 const 4, 10 imm.
- alu_op_sel  out  2  ALU operation: 00 add, 01 branch compare (funct3), 10 funct3/funct7 decode.
- pc_source  out  1  next-PC source: 0 ALU result (LSB cleared by datapath), 1 ALUOut.
- is_halted  out  1  machine halted.

## Operation
- States: IF, ID, EX, MEM, WB, HALT.
- Outputs not listed for a state are 0.
- IF: iord=0, mem_read=1, alu_src_a=00, alu_src_b=01.
  - While mem_ready=0, stay in IF with no write strobes.
  - When mem_ready=1, assert ir_write=1, pc_write=1, pc_source=0 (PC<=PC+4), then go to ID.
- ID: alu_src_a=10, alu_src_b=10; ALUOut latches old_pc+imm.
  - ECALL with x17_val==10: go to HALT.
  - ECALL otherwise: go to IF.
  - Any other opcode: go to EX.
- EX, by opcode:
  - R-type: alu_src_a=01, alu_src_b=00, alu_op_sel=10; go to WB.
  - I-arith: alu_src_a=01, alu_src_b=10, alu_op_sel=10; go to WB.
  - LOAD/STORE: alu_src_a=01, alu_src_b=10, add; go to MEM.
  - BRANCH: alu_src_a=01, alu_src_b=00, alu_op_sel=01, pc_write_cond=1, pc_source=1; go to IF.
  - JAL: pc_write=1, pc_source=1, reg_write=1, wb_sel=10; go to IF.
  - JALR: alu_src_a=01, alu_src_b=10, pc_write=1, pc_source=0, reg_write=1, wb_sel=10; go to IF.
  - Unknown opcode: go to IF with no strobes (NOP).
- MEM: iord=1.
  - LOAD: mem_read=1; go to WB on mem_ready.
  - STORE: mem_write=1; go to IF on mem_ready.
  - Stay in MEM while mem_ready=0.
- WB: reg_write=1; wb_sel=01 for LOAD, 00 otherwise; go to IF.
- HALT: is_halted=1, all strobes 0, terminal until reset.

## Timing
- The state register is the only storage. Outputs are combinational from state and opcode; pc_write and ir_write in IF are additionally gated by mem_ready.
- Asynchronous reset forces state to IF. While reset is high every output is 0, including mem_read; after release the first edge sees IF outputs.
- Cycles per instruction with mem_ready tied high:
  - R/I-arith: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH/JAL/JALR: 3.
  - ECALL: 2.
- Each mem_ready=0 cycle adds one cycle in IF or MEM.
- mem_ready is ignored outside IF and MEM.
- Reset asserted mid-instruction aborts it; no strobe is issued after the reset edge.
- opcode must remain stable from ID through WB; the IR is written only in IF.

## Configuration
- MC_PERF_CNT_EN defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0 asynchronously.
  - cycle_cnt increments every clock edge while not in HALT.
  - instret_cnt increments on every transition into IF from ID/EX/MEM/WB, and on entering HALT.
  - Both counters wrap modulo 2^32.
- MC_PERF_CNT_EN undefined: the ports and counters are absent.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum (3-bit);
  - opcode constants: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 1110011;
  - wb_sel, alu_src_a, alu_src_b and alu_op_sel encodings.
- One sub-module, mc_output_decoder: purely combinational (state, opcode, mem_ready) -> control outputs.
- The parent holds the state register, next-state logic and the optional counters.

## Test plan
- Reset released, mem_ready=1, IR=R-type ADD: states IF,ID,EX,WB,IF; reg_write=1 with wb_sel=00 only in WB; pc_write only in IF.
- LOAD with mem_ready low for 2 cycles in MEM: MEM lasts 3 cycles with mem_read=1, iord=1; WB has wb_sel=01; total 7 cycles.
- BRANCH: EX asserts pc_write_cond=1, pc_source=1, alu_op_sel=01, then IF; no reg_write anywhere.
- JALR: EX asserts pc_write=1, pc_source=0, reg_write=1, wb_sel=10; next state IF.
- ECALL with x17_val=10: ID -> HALT, is_halted=1 held for 100 cycles, all strobes 0. ECALL with x17_val=9: returns to IF.
- Reset pulsed while in MEM of a STORE: state IF immediately, mem_write drops asynchronously. With MC_PERF_CNT_EN: counters read 0, then instret_cnt=1 after the first completed ADD.
